// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller for the MIPS-subset datapath: sequences PC, IR,
// register file, ALU muxes and a shared single-port memory with ready stalls.
module mc_control_fsm (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  output logic       sign_ext_o,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       branch_ne_o,
  output logic [1:0] pc_src_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_ctrl_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BRANCH   = 4'd8,
    IMM_EX   = 4'd9,
    IMM_WB   = 4'd10,
    JUMP     = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  function automatic logic f_rtype_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic logic [3:0] f_rtype_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [3:0] f_imm_alu(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic state_t f_decode_next(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_LW, OP_SW:                     return MEMADR;
      OP_RTYPE:                         return f_rtype_legal(fn) ? RTYPE_EX : TRAP;
      OP_BEQ, OP_BNE:                   return BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return IMM_EX;
      OP_J:                             return JUMP;
      default:                          return TRAP;
    endcase
  endfunction

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = mem_ready_i ? DECODE : FETCH;
      DECODE:   w_next = f_decode_next(op_i, funct_i);
      MEMADR:   w_next = (op_i == OP_LW) ? MEMRD : ((op_i == OP_SW) ? MEMWR : FETCH);
      MEMRD:    w_next = mem_ready_i ? MEMWB : MEMRD;
      MEMWB:    w_next = FETCH;
      MEMWR:    w_next = mem_ready_i ? FETCH : MEMWR;
      RTYPE_EX: w_next = RTYPE_WB;
      RTYPE_WB: w_next = FETCH;
      BRANCH:   w_next = FETCH;
      IMM_EX:   w_next = IMM_WB;
      IMM_WB:   w_next = FETCH;
      JUMP:     w_next = FETCH;
      TRAP:     w_next = TRAP;
      default:  w_next = FETCH;
    endcase
  end

  logic       w_pc_write, w_pc_write_cond, w_branch_ne, w_i_or_d;
  logic       w_mem_read, w_mem_write, w_ir_write, w_reg_dst;
  logic       w_mem_to_reg, w_reg_write, w_alu_src_a, w_illegal;
  logic [1:0] w_pc_src, w_alu_src_b;
  logic [3:0] w_alu_ctrl;

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_branch_ne     = 1'b0;
    w_pc_src        = 2'd0;
    w_i_or_d        = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_dst       = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'd0;
    w_alu_ctrl      = 4'd0;
    w_illegal       = 1'b0;
    case (r_state)
      FETCH: begin
        // PC+4 is computed every fetch cycle but only committed with the IR
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'd1;
        w_alu_ctrl  = ALU_ADD;
        w_ir_write  = mem_ready_i;
        w_pc_write  = mem_ready_i;
      end
      DECODE: begin
        w_alu_src_b = 2'd3;
        w_alu_ctrl  = ALU_ADD;
      end
      MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'd2;
        w_alu_ctrl  = ALU_ADD;
      end
      MEMRD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
      end
      MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      MEMWR: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
      end
      RTYPE_EX: begin
        w_alu_src_a = 1'b1;
        w_alu_ctrl  = f_rtype_alu(funct_i);
      end
      RTYPE_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_ctrl      = ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_src        = 2'd1;
        w_branch_ne     = (op_i == OP_BNE);
      end
      IMM_EX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'd2;
        w_alu_ctrl  = f_imm_alu(op_i);
      end
      IMM_WB: begin
        w_reg_write = 1'b1;
      end
      JUMP: begin
        w_pc_write = 1'b1;
        w_pc_src   = 2'd2;
      end
      TRAP: begin
        w_illegal = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every strobe and select so a mid-transaction reset is side-effect free
  always_comb begin
    pc_write_o      = w_pc_write      & ~rst_i;
    pc_write_cond_o = w_pc_write_cond & ~rst_i;
    branch_ne_o     = w_branch_ne     & ~rst_i;
    pc_src_o        = rst_i ? 2'd0 : w_pc_src;
    i_or_d_o        = w_i_or_d        & ~rst_i;
    mem_read_o      = w_mem_read      & ~rst_i;
    mem_write_o     = w_mem_write     & ~rst_i;
    ir_write_o      = w_ir_write      & ~rst_i;
    reg_dst_o       = w_reg_dst       & ~rst_i;
    mem_to_reg_o    = w_mem_to_reg    & ~rst_i;
    reg_write_o     = w_reg_write     & ~rst_i;
    alu_src_a_o     = w_alu_src_a     & ~rst_i;
    alu_src_b_o     = rst_i ? 2'd0 : w_alu_src_b;
    alu_ctrl_o      = rst_i ? 4'd0 : w_alu_ctrl;
    illegal_o       = w_illegal       & ~rst_i;
    sign_ext_o      = ~((op_i == OP_ANDI) || (op_i == OP_ORI));
    state_o         = r_state;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: each cycle's expected output vector is queued
// when the inputs are driven and popped/compared once the outputs settle.
module tb_mc_control_fsm;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] op_i;
  logic [5:0] funct_i;
  logic       mem_ready_i;
  logic       sign_ext_o, pc_write_o, pc_write_cond_o, branch_ne_o;
  logic [1:0] pc_src_o;
  logic       i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
  logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [3:0] alu_ctrl_o;
  logic [3:0] state_o;
  logic       illegal_o;

  always #5 clk_i = ~clk_i;

  mc_control_fsm dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct_i(funct_i),
    .mem_ready_i(mem_ready_i), .sign_ext_o(sign_ext_o),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
    .branch_ne_o(branch_ne_o), .pc_src_o(pc_src_o), .i_or_d_o(i_or_d_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_ctrl_o(alu_ctrl_o),
    .state_o(state_o), .illegal_o(illegal_o)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, bne;
    logic [1:0] pcsrc;
    logic       iord, mr, mw, irw, rdst, m2r, rw, sa;
    logic [1:0] sb;
    logic [3:0] alu;
    logic       se, ill;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t z(input logic [3:0] st, input logic se);
    exp_t e = '0;
    e.st = st;
    e.se = se;
    return e;
  endfunction

  function automatic exp_t x_fetch(input logic rdy, input logic se);
    exp_t e = z(4'd0, se);
    e.mr = 1'b1; e.sb = 2'd1; e.alu = 4'd2; e.irw = rdy; e.pcw = rdy;
    return e;
  endfunction

  function automatic exp_t x_decode(input logic se);
    exp_t e = z(4'd1, se);
    e.sb = 2'd3; e.alu = 4'd2;
    return e;
  endfunction

  function automatic exp_t x_memadr(input logic se);
    exp_t e = z(4'd2, se);
    e.sa = 1'b1; e.sb = 2'd2; e.alu = 4'd2;
    return e;
  endfunction

  function automatic exp_t x_memrd(input logic se);
    exp_t e = z(4'd3, se);
    e.mr = 1'b1; e.iord = 1'b1;
    return e;
  endfunction

  function automatic exp_t x_memwb(input logic se);
    exp_t e = z(4'd4, se);
    e.rw = 1'b1; e.m2r = 1'b1;
    return e;
  endfunction

  function automatic exp_t x_memwr(input logic se);
    exp_t e = z(4'd5, se);
    e.mw = 1'b1; e.iord = 1'b1;
    return e;
  endfunction

  function automatic exp_t x_rex(input logic [3:0] alu, input logic se);
    exp_t e = z(4'd6, se);
    e.sa = 1'b1; e.alu = alu;
    return e;
  endfunction

  function automatic exp_t x_rwb(input logic se);
    exp_t e = z(4'd7, se);
    e.rw = 1'b1; e.rdst = 1'b1;
    return e;
  endfunction

  function automatic exp_t x_br(input logic bne, input logic se);
    exp_t e = z(4'd8, se);
    e.sa = 1'b1; e.alu = 4'd6; e.pcwc = 1'b1; e.pcsrc = 2'd1; e.bne = bne;
    return e;
  endfunction

  function automatic exp_t x_iex(input logic [3:0] alu, input logic se);
    exp_t e = z(4'd9, se);
    e.sa = 1'b1; e.sb = 2'd2; e.alu = alu;
    return e;
  endfunction

  function automatic exp_t x_iwb(input logic se);
    exp_t e = z(4'd10, se);
    e.rw = 1'b1;
    return e;
  endfunction

  function automatic exp_t x_jump(input logic se);
    exp_t e = z(4'd11, se);
    e.pcw = 1'b1; e.pcsrc = 2'd2;
    return e;
  endfunction

  function automatic exp_t x_trap(input logic se);
    exp_t e = z(4'd12, se);
    e.ill = 1'b1;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t e;
    e.st = state_o; e.pcw = pc_write_o; e.pcwc = pc_write_cond_o; e.bne = branch_ne_o;
    e.pcsrc = pc_src_o; e.iord = i_or_d_o; e.mr = mem_read_o; e.mw = mem_write_o;
    e.irw = ir_write_o; e.rdst = reg_dst_o; e.m2r = mem_to_reg_o; e.rw = reg_write_o;
    e.sa = alu_src_a_o; e.sb = alu_src_b_o; e.alu = alu_ctrl_o; e.se = sign_ext_o;
    e.ill = illegal_o;
    return e;
  endfunction

  // Drive one cycle's inputs (at the falling edge), queue its expectation,
  // then compare once the combinational outputs have settled.
  task automatic step(input string tag, input logic r, input logic [5:0] op,
                      input logic [5:0] fn, input logic rdy, input exp_t e);
    exp_t got;
    exp_t want;
    rst_i = r; op_i = op; funct_i = fn; mem_ready_i = rdy;
    sb_q.push_back(e);
    #1;
    got  = observed();
    want = sb_q.pop_front();
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (st %0d vs %0d)", tag, got, want, got.st, want.st);
    end
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; op_i = 6'h23; funct_i = 6'h00; mem_ready_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);

    // Reset state, with memory ready asserted to show strobes stay masked
    step("reset0", 1'b1, 6'h23, 6'h00, 1'b1, z(4'd0, 1'b1));
    step("reset1", 1'b1, 6'h23, 6'h00, 1'b0, z(4'd0, 1'b1));

    // lw, zero wait states: 0,1,2,3,4 then back to 0
    step("lw_fetch",  1'b0, 6'h23, 6'h00, 1'b1, x_fetch(1'b1, 1'b1));
    step("lw_decode", 1'b0, 6'h23, 6'h00, 1'b1, x_decode(1'b1));
    step("lw_memadr", 1'b0, 6'h23, 6'h00, 1'b1, x_memadr(1'b1));
    step("lw_memrd",  1'b0, 6'h23, 6'h00, 1'b1, x_memrd(1'b1));
    step("lw_memwb",  1'b0, 6'h23, 6'h00, 1'b1, x_memwb(1'b1));

    // Fetch stalled three cycles, then R-type sub
    step("stall_f0", 1'b0, 6'h00, 6'h22, 1'b0, x_fetch(1'b0, 1'b1));
    step("stall_f1", 1'b0, 6'h00, 6'h22, 1'b0, x_fetch(1'b0, 1'b1));
    step("stall_f2", 1'b0, 6'h00, 6'h22, 1'b0, x_fetch(1'b0, 1'b1));
    step("stall_f3", 1'b0, 6'h00, 6'h22, 1'b1, x_fetch(1'b1, 1'b1));
    step("sub_decode", 1'b0, 6'h00, 6'h22, 1'b0, x_decode(1'b1));
    step("sub_ex",     1'b0, 6'h00, 6'h22, 1'b1, x_rex(4'd6, 1'b1));
    step("sub_wb",     1'b0, 6'h00, 6'h22, 1'b0, x_rwb(1'b1));

    // R-type slt
    step("slt_fetch",  1'b0, 6'h00, 6'h2A, 1'b1, x_fetch(1'b1, 1'b1));
    step("slt_decode", 1'b0, 6'h00, 6'h2A, 1'b0, x_decode(1'b1));
    step("slt_ex",     1'b0, 6'h00, 6'h2A, 1'b0, x_rex(4'd7, 1'b1));
    step("slt_wb",     1'b0, 6'h00, 6'h2A, 1'b0, x_rwb(1'b1));

    // bne then beq
    step("bne_fetch",  1'b0, 6'h05, 6'h00, 1'b1, x_fetch(1'b1, 1'b1));
    step("bne_decode", 1'b0, 6'h05, 6'h00, 1'b0, x_decode(1'b1));
    step("bne_branch", 1'b0, 6'h05, 6'h00, 1'b0, x_br(1'b1, 1'b1));
    step("beq_fetch",  1'b0, 6'h04, 6'h00, 1'b1, x_fetch(1'b1, 1'b1));
    step("beq_decode", 1'b0, 6'h04, 6'h00, 1'b0, x_decode(1'b1));
    step("beq_branch", 1'b0, 6'h04, 6'h00, 1'b0, x_br(1'b0, 1'b1));

    // andi (zero-extend), ori, addi
    step("andi_fetch",  1'b0, 6'h0C, 6'h00, 1'b1, x_fetch(1'b1, 1'b0));
    step("andi_decode", 1'b0, 6'h0C, 6'h00, 1'b0, x_decode(1'b0));
    step("andi_ex",     1'b0, 6'h0C, 6'h00, 1'b0, x_iex(4'd0, 1'b0));
    step("andi_wb",     1'b0, 6'h0C, 6'h00, 1'b0, x_iwb(1'b0));
    step("ori_fetch",   1'b0, 6'h0D, 6'h00, 1'b1, x_fetch(1'b1, 1'b0));
    step("ori_decode",  1'b0, 6'h0D, 6'h00, 1'b0, x_decode(1'b0));
    step("ori_ex",      1'b0, 6'h0D, 6'h00, 1'b0, x_iex(4'd1, 1'b0));
    step("ori_wb",      1'b0, 6'h0D, 6'h00, 1'b0, x_iwb(1'b0));
    step("addi_fetch",  1'b0, 6'h08, 6'h00, 1'b1, x_fetch(1'b1, 1'b1));
    step("addi_decode", 1'b0, 6'h08, 6'h00, 1'b0, x_decode(1'b1));
    step("addi_ex",     1'b0, 6'h08, 6'h00, 1'b0, x_iex(4'd2, 1'b1));
    step("addi_wb",     1'b0, 6'h08, 6'h00, 1'b0, x_iwb(1'b1));

    // j
    step("j_fetch",  1'b0, 6'h02, 6'h00, 1'b1, x_fetch(1'b1, 1'b1));
    step("j_decode", 1'b0, 6'h02, 6'h00, 1'b0, x_decode(1'b1));
    step("j_jump",   1'b0, 6'h02, 6'h00, 1'b1, x_jump(1'b1));

    // sw with one wait state in MEMWR
    step("sw_fetch",  1'b0, 6'h2B, 6'h00, 1'b1, x_fetch(1'b1, 1'b1));
    step("sw_decode", 1'b0, 6'h2B, 6'h00, 1'b0, x_decode(1'b1));
    step("sw_memadr", 1'b0, 6'h2B, 6'h00, 1'b0, x_memadr(1'b1));
    step("sw_memwr0", 1'b0, 6'h2B, 6'h00, 1'b0, x_memwr(1'b1));
    step("sw_memwr1", 1'b0, 6'h2B, 6'h00, 1'b1, x_memwr(1'b1));

    // lw with a stalled MEMRD
    step("lws_fetch",  1'b0, 6'h23, 6'h00, 1'b1, x_fetch(1'b1, 1'b1));
    step("lws_decode", 1'b0, 6'h23, 6'h00, 1'b0, x_decode(1'b1));
    step("lws_memadr", 1'b0, 6'h23, 6'h00, 1'b0, x_memadr(1'b1));
    step("lws_memrd0", 1'b0, 6'h23, 6'h00, 1'b0, x_memrd(1'b1));
    step("lws_memrd1", 1'b0, 6'h23, 6'h00, 1'b1, x_memrd(1'b1));
    step("lws_memwb",  1'b0, 6'h23, 6'h00, 1'b0, x_memwb(1'b1));

    // Illegal R-type funct traps
    step("badfn_fetch",  1'b0, 6'h00, 6'h21, 1'b1, x_fetch(1'b1, 1'b1));
    step("badfn_decode", 1'b0, 6'h00, 6'h21, 1'b0, x_decode(1'b1));
    step("badfn_trap",   1'b0, 6'h00, 6'h21, 1'b1, x_trap(1'b1));
    step("trap_rst",     1'b1, 6'h00, 6'h21, 1'b1, z(4'd12, 1'b1));

    // Unsupported opcode traps and holds until reset
    step("op3f_fetch",  1'b0, 6'h3F, 6'h00, 1'b1, x_fetch(1'b1, 1'b1));
    step("op3f_decode", 1'b0, 6'h3F, 6'h00, 1'b0, x_decode(1'b1));
    step("op3f_trap0",  1'b0, 6'h3F, 6'h00, 1'b1, x_trap(1'b1));
    step("op3f_trap1",  1'b0, 6'h23, 6'h00, 1'b1, x_trap(1'b1));
    step("op3f_trap2",  1'b0, 6'h02, 6'h00, 1'b0, x_trap(1'b1));
    step("op3f_rst",    1'b1, 6'h2B, 6'h00, 1'b0, z(4'd12, 1'b1));

    // Reset in the middle of a stalled store
    step("swr_fetch",  1'b0, 6'h2B, 6'h00, 1'b1, x_fetch(1'b1, 1'b1));
    step("swr_decode", 1'b0, 6'h2B, 6'h00, 1'b0, x_decode(1'b1));
    step("swr_memadr", 1'b0, 6'h2B, 6'h00, 1'b0, x_memadr(1'b1));
    step("swr_memwr",  1'b0, 6'h2B, 6'h00, 1'b0, x_memwr(1'b1));
    step("swr_rst",    1'b1, 6'h2B, 6'h00, 1'b0, z(4'd5, 1'b1));
    step("swr_after",  1'b0, 6'h2B, 6'h00, 1'b0, x_fetch(1'b0, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle main controller for the MIPS-subset datapath.
- Consumes opcode/funct fields from the instruction decoder.
- Drives the decoder's sign-extension select and sequences every datapath strobe: PC, IR, register file, ALU muxes and memory.
- Supports stalls on a shared single-port memory through a ready handshake, and traps on unsupported instructions.

Parameters:
- (none; state and ALU encodings fixed below)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- op_i  in  6  opcode from decoder
- funct_i  in  6  funct from decoder
- mem_ready_i  in  1  memory completes read/write this cycle
- sign_ext_o  out  1  to decoder sign_ext_i
- pc_write_o  out  1  unconditional PC write
- pc_write_cond_o  out  1  branch PC write; datapath qualifies with (zero ^ branch_ne_o)
- branch_ne_o  out  1  1 = bne sense
- pc_src_o  out  2  0 ALU result, 1 ALUOut, 2 jump target
- i_or_d_o  out  1  0 PC address, 1 ALUOut address
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- ir_write_o  out  1  IR load
- reg_dst_o  out  1  0 rt, 1 rd
- mem_to_reg_o  out  1  0 ALUOut, 1 MDR
- reg_write_o  out  1  register file write
- alu_src_a_o  out  1  0 PC, 1 A
- alu_src_b_o  out  2  0 B, 1 const 4, 2 imm, 3 imm<<2
- alu_ctrl_o  out  4  0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT
- state_o  out  4  current state (debug)
- illegal_o  out  1  trap indicator

Behaviour:
- Reset:
  - rst_i high at any edge forces state FETCH (0), including mid-transaction.
  - While rst_i is high, all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) and illegal_o are 0.
  - All mux selects are 0 during reset.
- Outputs: combinational from state, op_i, funct_i and mem_ready_i. All unlisted strobes are 0 and unlisted selects are 0.
- States and actions:
  - FETCH(0): mem_read=1, i_or_d=0, src_a=0, src_b=1, alu=ADD, pc_src=0. ir_write=pc_write=1 only in the cycle mem_ready_i=1; that cycle -> DECODE, else stay.
  - DECODE(1): src_a=0, src_b=3, alu=ADD (branch target to ALUOut). Next state by op_i:
    - 0x23 lw / 0x2B sw -> MEMADR
    - 0x00 with funct in {0x20,0x22,0x24,0x25,0x2A} -> RTYPE_EX
    - 0x04 beq / 0x05 bne -> BRANCH
    - 0x08 addi / 0x0C andi / 0x0D ori / 0x0A slti -> IMM_EX
    - 0x02 j -> JUMP
    - anything else -> TRAP
  - MEMADR(2): src_a=1, src_b=2, alu=ADD; lw -> MEMRD, sw -> MEMWR.
  - MEMRD(3): mem_read=1, i_or_d=1; -> MEMWB when mem_ready_i=1, else stay.
  - MEMWB(4): reg_write=1, reg_dst=0, mem_to_reg=1; -> FETCH.
  - MEMWR(5): mem_write=1, i_or_d=1; -> FETCH when mem_ready_i=1, else stay.
  - RTYPE_EX(6): src_a=1, src_b=0, alu by funct (0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT); -> RTYPE_WB.
  - RTYPE_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0; -> FETCH.
  - BRANCH(8): src_a=1, src_b=0, alu=SUB, pc_write_cond=1, pc_src=1, branch_ne=(op_i==0x05); -> FETCH.
  - IMM_EX(9): src_a=1, src_b=2, alu by op (addi ADD, andi AND, ori OR, slti SLT); -> IMM_WB.
  - IMM_WB(10): reg_write=1, reg_dst=0, mem_to_reg=0; -> FETCH.
  - JUMP(11): pc_write=1, pc_src=2; -> FETCH.
  - TRAP(12): illegal_o=1, all strobes 0; stays until reset.
  - Unused encodings 13-15 -> FETCH next cycle, strobes 0.
- sign_ext_o: 0 when op_i is 0x0C or 0x0D, else 1, in every state.
- Instruction latency with zero wait states: lw 5, sw 4, R-type 4, imm 4, branch 3, j 3 cycles. Each mem_ready_i-low cycle in FETCH, MEMRD or MEMWR adds 1.
- mem_read_o/mem_write_o stay asserted and stable until mem_ready_i is seen. mem_ready_i in any other state is ignored.

Test Plan:
- Reset, then lw (op 0x23), mem_ready_i high -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; 5 cycles total.
- FETCH with mem_ready_i low 3 cycles -> mem_read=1 held 4 cycles; ir_write and pc_write each pulse once, in the 4th cycle only.
- R-type funct 0x22 -> alu_ctrl=6 in RTYPE_EX, reg_dst=1 in RTYPE_WB.
- bne (0x05) -> BRANCH with pc_write_cond=1, branch_ne=1, pc_src=1, alu=6. beq gives branch_ne=0.
- andi (0x0C) -> sign_ext_o=0, alu=0 in IMM_EX; addi -> sign_ext_o=1, alu=2.
- op 0x3F -> TRAP, illegal_o=1 held. rst_i during MEMWR with mem_ready_i low -> next state FETCH, mem_write_o=0 while rst_i high.
